// File: rtl/redun_mont_seq.sv
// rtl/redun_mont_seq.sv - iteration sequencer for the redundant-form Montgomery squaring loop
// Issues the working value to the squarer, feeds results back, and counts squarings to T.
module redun_mont_seq #(
  parameter int NUM_WRDS  = 65,
  parameter int WRD_BITS  = 16,
  parameter int ITER_BITS = 32,
  parameter int TIMEOUT   = 64,
  localparam int DW       = NUM_WRDS * WRD_BITS
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [DW-1:0]        i_sq_in,
  input  logic [ITER_BITS-1:0] i_iters,
  input  logic                 i_abort,
  input  logic                 i_dp_ready,
  output logic [DW-1:0]        o_mul_sq,
  output logic                 o_mul_val,
  input  logic [DW-1:0]        i_mul_out,
  input  logic                 i_mul_val,
  output logic [DW-1:0]        o_sq_out,
  output logic                 o_done,
  output logic                 o_busy,
  output logic                 o_err,
  output logic [ITER_BITS-1:0] o_iter_cnt
);

  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_RDY, S_ISSUE, S_WAIT_RES, S_DONE, S_ERR
  } state_t;

  state_t               state_q, state_d;
  logic [DW-1:0]        work_q, work_d;
  logic [ITER_BITS-1:0] tgt_q, tgt_d;
  logic [ITER_BITS-1:0] cnt_q, cnt_d;
  logic [ITER_BITS-1:0] cnt_inc;
  logic [TW-1:0]        to_q, to_d;
  logic [DW-1:0]        sq_out_q;
  logic                 mul_val_q, done_q, busy_q, err_q;
  logic                 start_ok;

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    tgt_d    = tgt_q;
    cnt_d    = cnt_q;
    to_d     = to_q;
    start_ok = 1'b0;
    cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    case (state_q)
      S_IDLE: start_ok = i_start;
      S_WAIT_RDY: begin
        if (i_abort)         state_d = S_IDLE;
        else if (i_dp_ready) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        to_d = '0;
        if (i_abort)          state_d = S_IDLE;
        else if (!i_dp_ready) state_d = S_ERR;
        else                  state_d = S_WAIT_RES;
      end
      S_WAIT_RES: begin
        // abort beats lock loss, which beats a result landing in the same cycle
        if (i_abort)          state_d = S_IDLE;
        else if (!i_dp_ready) state_d = S_ERR;
        else if (i_mul_val) begin
          work_d  = i_mul_out;
          cnt_d   = cnt_inc;
          state_d = (cnt_inc == tgt_q) ? S_DONE : S_ISSUE;
        end else if (to_q == TW'(TIMEOUT - 2)) begin
          state_d = S_ERR;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      S_ERR: begin
        if (i_abort) state_d = S_IDLE;
        else         start_ok = i_start;
      end
      default: state_d = S_IDLE;
    endcase

    if (start_ok) begin
      work_d = i_sq_in;
      tgt_d  = i_iters;
      cnt_d  = '0;
      if (i_iters == '0)   state_d = S_DONE;
      else if (i_dp_ready) state_d = S_ISSUE;
      else                 state_d = S_WAIT_RDY;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      work_q    <= '0;
      tgt_q     <= '0;
      cnt_q     <= '0;
      to_q      <= '0;
      sq_out_q  <= '0;
      mul_val_q <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      work_q    <= work_d;
      tgt_q     <= tgt_d;
      cnt_q     <= cnt_d;
      to_q      <= to_d;
      mul_val_q <= (state_d == S_ISSUE);
      done_q    <= (state_d == S_DONE);
      busy_q    <= (state_d != S_IDLE);
      if (state_d == S_DONE) sq_out_q <= work_d;
      if (start_ok)                err_q <= 1'b0;
      else if (state_d == S_ERR)   err_q <= 1'b1;
    end
  end

  assign o_mul_sq   = work_q;
  assign o_mul_val  = mul_val_q;
  assign o_sq_out   = sq_out_q;
  assign o_done     = done_q;
  assign o_busy     = busy_q;
  assign o_err      = err_q;
  assign o_iter_cnt = cnt_q;

endmodule
